// File: rtl/lo_normalizer.sv
// lo_normalizer: two-stage valid/ready pipeline that left-justifies a 9-bit value
// using the leading-one index from the upstream encoder; flags zero/inconsistent inputs.
module lo_normalizer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_a,
  input  logic [3:0] in_index,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_mant,
  output logic [3:0] out_exp,
  output logic       out_zero,
  output logic       out_err,
  output logic [7:0] zero_cnt
);
  logic       s1_valid, s2_ready, in_fire, s1_move, zero, err;
  logic [8:0] s1_a, mant;
  logic [3:0] s1_index, shift;
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign s1_move  = s1_valid && s2_ready;
  // a consistent index names exactly the top set bit, i.e. a >> index == 1
  always_comb begin
    zero  = s1_a == 9'd0;
    err   = !zero && (s1_index > 4'd8 || (s1_a >> s1_index) != 9'd1);
    shift = 4'd8 - s1_index;
    mant  = s1_a << shift;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= 9'd0;
      s1_index <= 4'd0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_index <= in_index;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant  <= 9'd0;
      out_exp   <= 4'd0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else if (s1_move) begin
      out_valid <= 1'b1;
      out_mant  <= (zero || err) ? 9'd0 : mant;
      out_exp   <= (zero || err) ? 4'd0 : s1_index;
      out_zero  <= zero;
      out_err   <= err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_cnt <= 8'd0;
    else if (in_fire && in_a == 9'd0 && zero_cnt != 8'hff) zero_cnt <= zero_cnt + 8'd1;
  end
endmodule

// File: tb/tb_lo_normalizer.sv
// tb_lo_normalizer: randomized and directed checks of lo_normalizer against a
// behavioural leading-one model with an in-order expectation queue.
module tb_lo_normalizer;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [8:0] in_a = 9'd0;
  logic [3:0] in_index = 4'd0;
  logic       in_ready, out_valid, out_zero, out_err;
  logic [8:0] out_mant;
  logic [3:0] out_exp;
  logic [7:0] zero_cnt;
  int n_checks = 0, n_fail = 0;
  logic [14:0] q[$];
  logic        o_valid, o_ir, o_in_fire, o_out_fire;
  logic [14:0] o_word;
  logic [7:0]  o_zc;
  int          o_qsize;

  lo_normalizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_index(in_index), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero), .out_err(out_err),
    .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  function automatic int msb(input logic [8:0] a);
    int p = -1;
    for (int b = 0; b < 9; b++) if (a[b]) p = b;
    return p;
  endfunction

  // expected {mant, exp, zero, err} straight from the arithmetic definition
  function automatic logic [14:0] model(input logic [8:0] a, input logic [3:0] idx);
    int p = msb(a);
    int m;
    if (a == 9'd0) return {9'd0, 4'd0, 2'b10};
    if (int'(idx) != p) return {9'd0, 4'd0, 2'b01};
    m = (int'(a) * (1 << (8 - p))) % 512;
    return {m[8:0], idx, 2'b00};
  endfunction

  function automatic logic [3:0] good_index(input logic [8:0] a);
    int p = msb(a);
    return (p < 0) ? 4'($urandom_range(0, 15)) : 4'(p);
  endfunction

  function automatic logic [3:0] rand_index(input logic [8:0] a);
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : good_index(a);
  endfunction

  task automatic step();
    @(negedge clk);
    o_valid    = out_valid;
    o_ir       = in_ready;
    o_word     = {out_mant, out_exp, out_zero, out_err};
    o_zc       = zero_cnt;
    o_in_fire  = in_valid && in_ready;
    o_out_fire = out_valid && out_ready;
    o_qsize    = q.size();
    if (o_in_fire) q.push_back(model(in_a, in_index));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      in_a = 9'($urandom);
      in_index = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || zero_cnt !== 8'd0 || {out_mant, out_exp, out_zero, out_err} !== 15'd0) begin
        n_fail++;
        $display("FAIL reset_hold: out_valid=%b zero_cnt=%0d word=%h, required 0/0/0", out_valid, zero_cnt,
                 {out_mant, out_exp, out_zero, out_err});
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (o_ir !== 1'b1 || o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", o_ir, o_valid);
      end
    end
  endtask

  task automatic test_single();
    logic [8:0]  t_a[5] = '{9'h016, 9'h100, 9'h000, 9'h016, 9'h001};
    logic [3:0]  t_i[5] = '{4'd4, 4'd8, 4'd7, 4'd2, 4'd9};
    logic [14:0] t_w[5] = '{{9'b101100000, 4'd4, 2'b00}, {9'h100, 4'd8, 2'b00}, {9'd0, 4'd0, 2'b10},
                            {9'd0, 4'd0, 2'b01}, {9'd0, 4'd0, 2'b01}};
    logic [7:0]  zc0;
    logic [14:0] e;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_a = t_a[k];
      in_index = t_i[k];
      step();
      zc0 = o_zc;
      in_valid = 1'b0;
      n_checks++;
      if (o_in_fire !== 1'b1) begin
        n_fail++;
        $display("FAIL single_accept[%0d]: in_ready=%b, required 1", k, o_ir);
      end
      step();
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_latency[%0d]: out_valid=%b one edge after accept, required 0", k, o_valid);
      end
      step();
      n_checks++;
      if (o_valid !== 1'b1 || o_word !== t_w[k] || o_zc !== zc0 + 8'(t_a[k] == 9'd0)) begin
        n_fail++;
        $display("FAIL single[%0d]: valid=%b word=%h zero_cnt=%0d, required 1 %h %0d", k, o_valid, o_word, o_zc,
                 t_w[k], zc0 + 8'(t_a[k] == 9'd0));
      end
      if (o_out_fire) begin
        e = q.pop_front();
        n_checks++;
        if (o_word !== e) begin
          n_fail++;
          $display("FAIL single_model[%0d]: word=%h, model %h", k, o_word, e);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int got = 0;
    logic [14:0] e;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 530 && got < 512; c++) begin
      in_valid = c < 512;
      in_a = 9'(c);
      in_index = good_index(9'(c));
      step();
      if (c < 512) begin
        n_checks++;
        if (o_ir !== 1'b1) begin
          n_fail++;
          $display("FAIL sweep_ready[%0d]: in_ready=%b, required 1", c, o_ir);
        end
      end
      if (o_out_fire) begin
        e = (o_qsize == 0) ? 15'h7fff : q.pop_front();
        n_checks++;
        if (o_word !== e || c != got + 2) begin
          n_fail++;
          $display("FAIL sweep_out[%0d]: word=%h at cycle %0d, required %h at cycle %0d", got, o_word, c, e, got + 2);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 512 || zero_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL sweep_total: outputs=%0d zero_cnt=%0d, required 512/1", got, zero_cnt);
    end
  endtask

  task automatic stream(input string name, input int n_in, input int max_cyc, input bit pattern);
    logic [8:0]  vals[$];
    logic        rp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        hold = 1'b0;
    logic [14:0] prev = 15'd0, e;
    int sent = 0, got = 0;
    for (int i = 0; i < n_in; i++) vals.push_back(9'($urandom));
    in_a = vals[0];
    in_index = rand_index(vals[0]);
    for (int c = 0; c < max_cyc && got < n_in; c++) begin
      out_ready = pattern ? rp[c % 6] : 1'($urandom);
      in_valid = sent < n_in && (pattern || $urandom_range(0, 3) != 0);
      step();
      n_checks++;
      if (o_ir !== !(o_qsize == 2 && !out_ready)) begin
        n_fail++;
        $display("FAIL %s_ready[%0d]: in_ready=%b with %0d in flight, out_ready=%b", name, c, o_ir, o_qsize, out_ready);
      end
      if (hold) begin
        n_checks++;
        if (o_valid !== 1'b1 || o_word !== prev) begin
          n_fail++;
          $display("FAIL %s_hold[%0d]: valid=%b word=%h, required 1 %h", name, c, o_valid, o_word, prev);
        end
      end
      hold = o_valid && !out_ready;
      prev = o_word;
      if (o_out_fire) begin
        e = (o_qsize == 0) ? 15'h7fff : q.pop_front();
        n_checks++;
        if (o_word !== e) begin
          n_fail++;
          $display("FAIL %s_out[%0d]: word=%h, required %h", name, got, o_word, e);
        end
        got++;
      end
      if (o_in_fire) begin
        sent++;
        if (sent < n_in) begin
          in_a = vals[sent];
          in_index = rand_index(vals[sent]);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != n_in || q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_count: outputs=%0d pending=%0d, required %0d/0", name, got, q.size(), n_in);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    stream("bp", 5, 60, 1'b1);
    do_reset();
    stream("rand", 200, 2000, 1'b0);
  endtask

  task automatic test_saturation();
    int got = 0;
    logic [14:0] e;
    do_reset();
    out_ready = 1'b1;
    in_a = 9'd0;
    for (int c = 0; c < 320 && got < 300; c++) begin
      in_valid = c < 300;
      in_index = 4'($urandom);
      step();
      if (o_out_fire) begin
        e = (o_qsize == 0) ? 15'h7fff : q.pop_front();
        n_checks++;
        if (o_word !== e) begin
          n_fail++;
          $display("FAIL sat_out[%0d]: word=%h, required %h", got, o_word, e);
        end
        got++;
      end
      if (c == 255) begin
        n_checks++;
        if (o_zc !== 8'd255) begin
          n_fail++;
          $display("FAIL sat_reach: zero_cnt=%0d after 255 zeros, required 255", o_zc);
        end
      end
    end
    n_checks++;
    if (zero_cnt !== 8'd255 || got != 300) begin
      n_fail++;
      $display("FAIL sat_final: zero_cnt=%0d outputs=%0d, required 255/300", zero_cnt, got);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 9'(i + 3);
      in_index = good_index(9'(i + 3));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_full: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || zero_cnt !== 8'd0 ||
        {out_mant, out_exp, out_zero, out_err} !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_async: out_valid=%b in_ready=%b zero_cnt=%0d word=%h, required 0/1/0/0", out_valid, in_ready,
               zero_cnt, {out_mant, out_exp, out_zero, out_err});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_stale[%0d]: out_valid=%b after reset, required 0", i, o_valid);
      end
    end
    in_valid = 1'b1;
    in_a = 9'h0a5;
    in_index = 4'd7;
    step();
    in_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (o_valid !== 1'b1 || o_word !== {9'h14a, 4'd7, 2'b00}) begin
      n_fail++;
      $display("FAIL mid_resume: valid=%b word=%h, required 1 %h", o_valid, o_word, {9'h14a, 4'd7, 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lo_normalizer.md
# lo_normalizer

Pipelined normalizer that sits directly downstream of the 9-bit leading-one encoder. It accepts a raw 9-bit value together with the encoder's 4-bit leading-one index and left-shifts the value so its leading one lands in bit 8. It emits the normalized mantissa and exponent (the index), flags zero and inconsistent inputs, and counts zero inputs. Flow control on both sides is a valid/ready handshake; the block sustains one transaction per cycle.

## Interface
- No parameters; all widths are fixed at 9-bit data and 4-bit index.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept input this cycle
- in_a  in  9  raw value (the encoder's input)
- in_index  in  4  encoder output: bit position of the most significant 1 of in_a (0–8)
- out_valid  out  1  output transaction present
- out_ready  in  1  consumer accepts output this cycle
- out_mant  out  9  in_a << (8 − in_index)
- out_exp  out  4  in_index
- out_zero  out  1  in_a was 0
- out_err  out  1  in_index inconsistent with in_a
- zero_cnt  out  8  saturating count of accepted zero inputs

## Operation
- Two register stages: S1 (capture) and S2 (output).
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage readiness:
  - s2_ready = !out_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready (combinational through both stages).
- S1 captures in_a and in_index on an input transfer and sets s1_valid.
  - s1_valid clears when S1 moves to S2 without a new input arriving in the same cycle.
- S2 loads from S1 whenever s1_valid && s2_ready, and sets out_valid.
  - out_valid clears on an output transfer when no S1 data moves in that cycle.
- S2 result computation (error and zero take priority over normal):
  - err = (a ≠ 0) && (index > 8 || a[index] == 0 || (a >> index) ≠ 1).
  - zero: a == 0 gives out_zero=1, out_mant=0, out_exp=0, out_err=0. The index input is ignored.
  - err: out_err=1, out_mant=0, out_exp=0, out_zero=0.
  - normal: out_mant = a << (8 − index), truncated to 9 bits, so bit 8 is always 1. out_exp = index.
- zero_cnt increments on each input transfer with in_a == 0.
  - It saturates at 255 and never wraps.
  - It is cleared only by reset.
- Output fields hold stable while out_valid && !out_ready. Inputs are sampled only on a transfer.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - out_valid=0, internal s1_valid=0.
  - out_mant=0, out_exp=0, out_zero=0, out_err=0, zero_cnt=0.
  - in_ready=1 once reset is released.
- Latency: an input accepted at edge N produces out_valid=1 after edge N+1, provided S2 was free.
- Throughput: 1 per cycle with out_ready held high. No bubbles between back-to-back transfers.
- Backpressure (out_ready=0, pipeline full): in_ready=0. Both stages hold and no data is lost or duplicated.
- Pipeline drain: when out_ready rises, in_ready rises in the same cycle. A simultaneous input and output transfer keeps the pipeline full.
- Reset asserted mid-operation: all in-flight transactions are discarded. No output appears after release until a new input is accepted.
- Ordering is strictly preserved.

## Test plan
- Reset: hold rst_n=0 with random inputs → out_valid=0, zero_cnt=0. After release, in_ready=1 and out_valid stays 0.
- Single normal value: in_a=9'b000010110, in_index=4 → two edges later out_mant=9'b101100000, out_exp=4, out_zero=0, out_err=0. Also in_a=9'h100, index=8 → out_mant=9'h100, out_exp=8.
- Zero and error cases:
  - in_a=0 with index=7 → out_zero=1, out_mant=0, zero_cnt increments.
  - in_a=9'b000010110 with index=2 → out_err=1.
  - in_a=1 with index=9 → out_err=1.
- Full sweep: all 512 values of in_a, each with the correct index, back-to-back with out_ready=1 → 512 outputs on consecutive cycles matching the formula. zero_cnt=1 at the end.
- Backpressure: stream 5 values while out_ready toggles 1,0,0,1,0,1… → every value appears exactly once and in order. in_ready=0 whenever both stages are full and out_ready=0.
- Saturation and reset mid-stream:
  - Send 300 zeros → zero_cnt=255.
  - Pulse rst_n low with the pipeline full → outputs return to reset values immediately and no stale output appears afterward.
